// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op encodings, FSM state type and
// the per-op execution latency.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Illegal ops (1xx) and divide-by-zero
  function automatic logic op_err(input logic [2:0] op, input logic div0);
    return op[2] || (op == OP_DIV && div0);
  endfunction

  // EXEC cycles for an op; error cases finish in a single cycle
  function automatic int op_lat(input logic [2:0] op, input logic div0,
                                input int mul_lat, input int div_lat);
    if (op_err(op, div0)) return 1;
    case (op)
      OP_MUL:  return mul_lat;
      OP_DIV:  return div_lat;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU: add/sub/mul/unsigned div on zero-extended
// operands; produces 0 when invalid is high or the divisor is zero.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]         op,
  input  logic               invalid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] ax, bx;
  assign ax = {{WIDTH{1'b0}}, a};
  assign bx = {{WIDTH{1'b0}}, b};

  // Datapath select; sub wraps modulo 2^(2*WIDTH)
  always_comb begin
    result = '0;
    if (!invalid) begin
      case (op)
        OP_ADD:  result = ax + bx;
        OP_SUB:  result = ax - bx;
        OP_MUL:  result = ax * bx;
        OP_DIV:  result = (b == '0) ? '0 : ax / bx;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// NREQ-wide round-robin arbiter. Grant is combinational from req starting at
// ptr; ptr moves to one past the winner when en is high.
module alu_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   gidx,
  output logic            hit
);

  logic [IW-1:0] ptr;
  int            idx;

  // First asserted request at or after ptr, wrapping
  always_comb begin
    grant = '0;
    gidx  = '0;
    hit   = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IW'(idx);
      end
    end
  end

  // Pointer advances past the winner on each accepted grant
  always_ff @(posedge clk) begin
    if (rst)                 ptr <= '0;
    else if (en && hit)      ptr <= (int'(gidx) == NREQ-1) ? '0 : gidx + 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one ALU among NREQ requesters.
// Optional error statistics: define ALU_ARBITER_STATS_EN to build err_count.
module alu_arbiter import alu_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [3*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_in0,
  input  logic [WIDTH*NREQ-1:0]    req_in1,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic                     rsp_zero,
  output logic                     rsp_error,
  output logic [15:0]              err_count
);

  localparam int IW   = $clog2(NREQ);
  localparam int LMAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;

  state_t             state, state_nx;
  logic [NREQ-1:0]    grant;
  logic [IW-1:0]      gidx, id_q;
  logic               hit, take, err_now, done;
  logic [2:0]         op_sel, op_q;
  logic [WIDTH-1:0]   a_sel, b_sel, a_q, b_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] alu_res;

  assign take      = (state == IDLE) && hit;
  assign req_ready = (state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign op_sel    = req_op[3*gidx +: 3];
  assign a_sel     = req_in0[WIDTH*gidx +: WIDTH];
  assign b_sel     = req_in1[WIDTH*gidx +: WIDTH];
  assign err_now   = op_err(op_q, b_q == '0);
  assign done      = (state == EXEC) && (cnt == '0);

  alu_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk), .rst(rst), .req(req_valid), .en(state == IDLE),
    .grant(grant), .gidx(gidx), .hit(hit)
  );

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op(op_q), .invalid(op_q[2]), .a(a_q), .b(b_q), .result(alu_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hit) state_nx = EXEC;
      EXEC:    if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, latency counter and registered response fields
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      cnt       <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_error <= 1'b0;
    end else begin
      if (take) begin
        op_q <= op_sel;
        a_q  <= a_sel;
        b_q  <= b_sel;
        id_q <= gidx;
        cnt  <= CW'(op_lat(op_sel, b_sel == '0, MUL_LAT, DIV_LAT) - 1);
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done) begin
        rsp_id    <= id_q;
        rsp_data  <= err_now ? '0 : alu_res;
        rsp_error <= err_now;
        rsp_zero  <= !err_now && (alu_res == '0);
      end
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  // Saturating count of error responses handed off
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (rsp_valid && rsp_ready && rsp_error && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule
